// File: rtl/display_scheduler.sv
// Round-robin time-sharing of the 4-digit seven-segment display between four requesters.
// The winner holds the display for a programmable dwell, with freeze (lock) and manual step (advance).
module display_scheduler #(
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [63:0] src_data,
  input  logic        lock,
  input  logic        advance,
  output logic [3:0]  grant,
  output logic [1:0]  active_id,
  output logic        busy,
  output logic [15:0] reg_to_display
);

  localparam int CW = $clog2(DWELL_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e        state_q, state_d;
  logic [3:0]    grant_q, grant_d;
  logic [1:0]    active_id_q, active_id_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   disp_q, disp_d;

  logic [1:0]    pick_id;
  logic          pick_found;
  logic [1:0]    scan_idx;
  logic [15:0]   owner_data;
  logic [15:0]   pick_data;
  logic          rearb;

  // Scan last+1 .. last+4 (the last step wraps back onto the current owner).
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    pick_id    = last_q;
    pick_found = 1'b0;
    scan_idx   = last_q;
    for (int i = 1; i <= 4; i++) begin
      scan_idx = last_q + 2'(i);
      if (!pick_found && req[scan_idx]) begin
        pick_id    = scan_idx;
        pick_found = 1'b1;
      end
    end
  end

  assign owner_data = src_data[{active_id_q, 4'b0000} +: 16];
  assign pick_data  = src_data[{pick_id, 4'b0000} +: 16];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    active_id_d = active_id_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    disp_d      = disp_q;
    rearb       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req) rearb = 1'b1;
      end
      HOLD: begin
        disp_d = owner_data;
        if (lock) begin
          // Frozen: grant and dwell counter hold, advance is dropped.
        end else if (!req[active_id_q] || advance || (cnt_q == '0)) begin
          rearb = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (rearb) begin
      if (|req) begin
        state_d     = HOLD;
        grant_d     = 4'b0001 << pick_id;
        active_id_d = pick_id;
        last_d      = pick_id;
        cnt_d       = CNT_LOAD;
        disp_d      = pick_data;
      end else begin
        // Nobody left: display value and owner index keep their last values.
        state_d = IDLE;
        grant_d = 4'b0000;
        disp_d  = disp_q;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant_q     <= 4'b0000;
      active_id_q <= 2'd0;
      last_q      <= 2'd3;
      cnt_q       <= '0;
      disp_q      <= 16'h0000;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      active_id_q <= active_id_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      disp_q      <= disp_d;
    end
  end

  assign grant          = grant_q;
  assign active_id      = active_id_q;
  assign busy           = (state_q == HOLD);
  assign reg_to_display = disp_q;

endmodule
